// File: rtl/mldsa_pkg.sv
// rtl/mldsa_pkg.sv - ML-DSA shared constants, eta encoding and sampler FSM states
package mldsa_pkg;

   localparam int N      = 256;
   localparam int Q      = 8380417;
   localparam int COEF_W = 23;

   typedef enum logic {
      ETA2 = 1'b0,
      ETA4 = 1'b1
   } eta_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // b mod 5 for a half-byte, as a table instead of a divider
   function automatic logic [2:0] mod5(input logic [3:0] b);
      logic [2:0] r;
      r = 3'd0;
      case (b)
         4'd1, 4'd6, 4'd11:  r = 3'd1;
         4'd2, 4'd7, 4'd12:  r = 3'd2;
         4'd3, 4'd8, 4'd13:  r = 3'd3;
         4'd4, 4'd9, 4'd14:  r = 3'd4;
         default:            r = 3'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/expand_s_rej_sampler_if.sv
// rtl/expand_s_rej_sampler_if.sv - squeeze-word input and coefficient output bundle
// Optional rej_cnt signal present when EXPANDS_REJ_CNT_EN is defined.
interface expand_s_rej_sampler_if;
   import mldsa_pkg::*;

   logic              start;
   logic              eta_sel;
   logic [63:0]       word_in;
   logic              word_valid;
   logic              word_ready;
   logic [COEF_W-1:0] coef_out;
   logic [7:0]        coef_idx;
   logic              coef_valid;
   logic              coef_ready;
   logic              busy;
   logic              done;
`ifdef EXPANDS_REJ_CNT_EN
   logic [11:0]       rej_cnt;
`endif

   modport slave (
      input  start, eta_sel, word_in, word_valid, coef_ready,
      output word_ready, coef_out, coef_idx, coef_valid, busy, done
`ifdef EXPANDS_REJ_CNT_EN
      , output rej_cnt
`endif
   );

   modport master (
      output start, eta_sel, word_in, word_valid, coef_ready,
      input  word_ready, coef_out, coef_idx, coef_valid, busy, done
`ifdef EXPANDS_REJ_CNT_EN
      , input rej_cnt
`endif
   );

endinterface

// File: rtl/rej_eta_map.sv
// rtl/rej_eta_map.sv - half-byte rejection test and mapping to [-eta, eta] mod Q
module rej_eta_map
   import mldsa_pkg::*;
(
   input  logic [3:0]        nibble,
   input  logic              eta_sel,
   output logic              accept,
   output logic [COEF_W-1:0] coef
);

   logic [3:0] x;
   logic [3:0] e;

   always_comb begin
      accept = 1'b0;
      x      = 4'd0;
      e      = 4'd0;
      coef   = '0;
      if (eta_sel == ETA4) begin
         accept = (nibble < 4'd9);
         x      = nibble;
         e      = 4'd4;
      end else begin
         accept = (nibble < 4'd15);
         x      = {1'b0, mod5(nibble)};
         e      = 4'd2;
      end
      // value is e - x; negatives wrap to Q + (e - x)
      if (x <= e)
         coef = COEF_W'(e - x);
      else
         coef = COEF_W'(Q) + COEF_W'(e) - COEF_W'(x);
   end

endmodule

// File: rtl/expand_s_rej_sampler.sv
// rtl/expand_s_rej_sampler.sv - RejBoundedPoly sampler on the SHAKE256 squeeze stream
// Optional: EXPANDS_REJ_CNT_EN adds a saturating rejected-nibble counter on rej_cnt.
module expand_s_rej_sampler
   import mldsa_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   expand_s_rej_sampler_if.slave   bus
);

   state_t            state;
   state_t            state_nx;
   logic              eta_q;
   logic [63:0]       wbuf;
   logic              wbuf_vld;
   logic [3:0]        ptr;
   logic [7:0]        cnt;

   logic [3:0]        nib;
   logic              acc;
   logic [COEF_W-1:0] coef;
   logic              run;
   logic              exam;
   logic              coef_hs;
   logic              consumed;
   logic              last_hs;
   logic              word_hs;

   assign nib = wbuf[{ptr, 2'b00} +: 4];

   rej_eta_map u_map (
      .nibble  (nib),
      .eta_sel (eta_q),
      .accept  (acc),
      .coef    (coef)
   );

   assign run      = (state == S_RUN);
   assign exam     = run & wbuf_vld;
   assign coef_hs  = exam & acc & bus.coef_ready;
   assign consumed = exam & (~acc | bus.coef_ready);
   assign last_hs  = coef_hs & (cnt == 8'd255);

   // refill when empty or while the last nibble drains; never on the final coefficient
   assign bus.word_ready = run & (~wbuf_vld | ((ptr == 4'd15) & consumed)) & ~last_hs;
   assign word_hs        = bus.word_valid & bus.word_ready;

   assign bus.coef_valid = exam & acc;
   assign bus.coef_out   = bus.coef_valid ? coef : '0;
   assign bus.coef_idx   = cnt;
   assign bus.busy       = run;
   assign bus.done       = (state == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.start) state_nx = S_RUN;
         S_RUN:   if (last_hs)   state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         eta_q    <= 1'b0;
         wbuf     <= '0;
         wbuf_vld <= 1'b0;
         ptr      <= 4'd0;
         cnt      <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  eta_q    <= bus.eta_sel;
                  wbuf_vld <= 1'b0;
                  ptr      <= 4'd0;
                  cnt      <= 8'd0;
               end
            end
            S_RUN: begin
               if (coef_hs)
                  cnt <= cnt + 8'd1;
               // polynomial complete: discard whatever is left of the word
               if (last_hs) begin
                  wbuf_vld <= 1'b0;
                  ptr      <= 4'd0;
               end else begin
                  if (consumed) begin
                     ptr <= ptr + 4'd1;
                     if (ptr == 4'd15)
                        wbuf_vld <= 1'b0;
                  end
                  if (word_hs) begin
                     wbuf     <= bus.word_in;
                     wbuf_vld <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef EXPANDS_REJ_CNT_EN
   logic [11:0] rej_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rej_q <= 12'd0;
      else if ((state == S_IDLE) && bus.start)
         rej_q <= 12'd0;
      else if (consumed && !acc && (rej_q != 12'hFFF))
         rej_q <= rej_q + 12'd1;
   end

   assign bus.rej_cnt = rej_q;
`endif

endmodule

// File: tb/tb_expand_s_rej_sampler.sv
// tb/tb_expand_s_rej_sampler.sv - randomized bench against a RejBoundedPoly reference model
module tb_expand_s_rej_sampler;
   import mldsa_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   expand_s_rej_sampler_if bus();

   expand_s_rej_sampler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] words[80];
   int          nwords = 80;
   int          exp_coef[256];
   int          exp_n, exp_rej, exp_last_word;
   int          obs[256];
   int          first_word_cyc, last_word_cyc, n_word_hs;
   int          first_coef_cyc, last_coef_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // RejBoundedPoly over the words[] stream, straight from the arithmetic definition
   task automatic model(input bit eta);
      exp_n = 0;
      exp_rej = 0;
      exp_last_word = -1;
      for (int w = 0; w < nwords; w++) begin
         for (int k = 0; k < 16; k++) begin
            if (exp_n < 256) begin
               int  b, v;
               bit  ok;
               b = int'((words[w] >> (4 * k)) & 64'hF);
               if (eta == 1'b0) begin
                  ok = (b < 15);
                  v  = 2 - (b % 5);
               end else begin
                  ok = (b < 9);
                  v  = 4 - b;
               end
               if (ok) begin
                  exp_coef[exp_n] = (v < 0) ? Q + v : v;
                  exp_n++;
                  if (exp_n == 256) exp_last_word = w;
               end else begin
                  exp_rej++;
               end
            end
         end
      end
   endtask

   task automatic fill_random(input int from);
      for (int i = from; i < nwords; i++) words[i] = {$urandom, $urandom};
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cvalid"}, bus.coef_valid, 0);
      check({tag, "_cout"},   bus.coef_out, 0);
      check({tag, "_cidx"},   bus.coef_idx, 0);
      check({tag, "_wready"}, bus.word_ready, 0);
      check({tag, "_busy"},   bus.busy, 0);
      check({tag, "_done"},   bus.done, 0);
`ifdef EXPANDS_REJ_CNT_EN
      check({tag, "_rejcnt"}, bus.rej_cnt, 0);
`endif
   endtask

   task automatic run_poly(input string tag, input bit eta, input int ready_pct,
                           input int valid_pct, input int abort_idx);
      int          wi = 0;
      int          nc = 0;
      bit          fin = 1'b0;
      bit          prev_stall = 1'b0;
      logic [31:0] prev_coef = 0;
      model(eta);
      first_word_cyc = -1; last_word_cyc = -1; n_word_hs = 0;
      first_coef_cyc = -1; last_coef_cyc = -1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.eta_sel = eta;
      bus.word_valid = 1'b0;
      bus.coef_ready = 1'b0;
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         @(negedge clk);
         bus.start      = 1'b0;
         bus.word_valid = (wi < nwords) && (int'($urandom_range(99)) < valid_pct);
         bus.word_in    = bus.word_valid ? words[wi] : {$urandom, $urandom};
         bus.coef_ready = int'($urandom_range(99)) < ready_pct;
         #1;
         if (bus.done) begin
            check({tag, "_done_wready"}, bus.word_ready, 0);
            check({tag, "_done_cvalid"}, bus.coef_valid, 0);
            fin = 1'b1;
         end else begin
            check({tag, "_busy"}, bus.busy, 1);
            if (prev_stall) begin
               check({tag, "_hold_valid"}, bus.coef_valid, 1);
               check({tag, "_hold_coef"}, bus.coef_out, prev_coef);
            end
            if (bus.coef_valid && nc == abort_idx) begin
               reset = 1'b1;
               #1;
               check_idle_outputs({tag, "_rst"});
               @(negedge clk);
               reset = 1'b0;
               bus.word_valid = 1'b0;
               bus.coef_ready = 1'b0;
               return;
            end
            if (bus.coef_valid && bus.coef_ready) begin
               if (nc < 256) begin
                  check({tag, "_coef"}, bus.coef_out, exp_coef[nc]);
                  check({tag, "_idx"}, bus.coef_idx, nc[7:0]);
                  obs[nc] = int'(bus.coef_out);
               end else begin
                  check({tag, "_extra_coef"}, nc, 255);
               end
               if (nc == 255) check({tag, "_last_wready"}, bus.word_ready, 0);
               if (first_coef_cyc < 0) first_coef_cyc = cyc;
               last_coef_cyc = cyc;
               nc++;
            end
            prev_stall = bus.coef_valid && !bus.coef_ready;
            prev_coef  = 32'(bus.coef_out);
            if (bus.word_valid && bus.word_ready) begin
               if (first_word_cyc < 0) first_word_cyc = cyc;
               last_word_cyc = cyc;
               n_word_hs++;
               wi++;
            end
         end
      end
      check({tag, "_done_seen"}, fin, 1);
      check({tag, "_ncoef"}, nc, 256);
      check({tag, "_nwords"}, wi, exp_last_word + 1);
`ifdef EXPANDS_REJ_CNT_EN
      check({tag, "_rejcnt"}, bus.rej_cnt, exp_rej);
`endif
      @(negedge clk);
      #1;
      check({tag, "_done_once"}, bus.done, 0);
      check({tag, "_busy_after"}, bus.busy, 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.eta_sel = 1'b0;
      bus.word_in = '0;
      bus.word_valid = 1'b0;
      bus.coef_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;

      // low nibbles 0,1,4,7,F with eta=2
      fill_random(1);
      words[0] = 64'h00000000000F7410;
      run_poly("eta2_dir", 1'b0, 100, 100, -1);
      check("eta2_dir_c0", obs[0], 2);
      check("eta2_dir_c1", obs[1], 1);
      check("eta2_dir_c2", obs[2], 8380415);
      check("eta2_dir_c3", obs[3], 0);

      // nibbles 8,9,0,3 with eta=4
      fill_random(1);
      words[0] = 64'h1111111111113098;
      run_poly("eta4_dir", 1'b1, 100, 100, -1);
      check("eta4_dir_c0", obs[0], 8380413);
      check("eta4_dir_c1", obs[1], 4);
      check("eta4_dir_c2", obs[2], 1);

      // all-zero stream at full rate
      for (int i = 0; i < nwords; i++) words[i] = '0;
      run_poly("zero", 1'b0, 100, 100, -1);
      check("zero_first_lat", first_coef_cyc - first_word_cyc, 1);
      check("zero_span", last_coef_cyc - first_coef_cyc, 255);
      check("zero_word_hs", n_word_hs, 16);
      check("zero_word_span", last_word_cyc - first_word_cyc, 240);
      check("zero_val", obs[200], 2);

      for (int r = 0; r < 3; r++) begin
         fill_random(0);
         run_poly("rand_eta4", 1'b1, 50, 70, -1);
      end
      fill_random(0);
      run_poly("rand_eta2", 1'b0, 60, 60, -1);

      // 256th accepted nibble sits at k=5 of word 16
      for (int i = 0; i < nwords; i++) words[i] = '0;
      words[0] = 64'h0000000000FFFFFF;
      fill_random(17);
      run_poly("k5_end", 1'b0, 100, 100, -1);
      fill_random(0);
      run_poly("after_k5", 1'b1, 80, 90, -1);

      // reset while coefficient 100 is presented, then a clean restart
      fill_random(0);
      run_poly("abort", 1'b0, 80, 90, 100);
      fill_random(0);
      run_poly("post_abort", 1'b1, 70, 80, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/expand_s_rej_sampler.md
Name: expand_s_rej_sampler

Overview:
- Downstream consumer of the SHAKE256 squeeze stream during ExpandS (KeyGen).
- Implements RejBoundedPoly from FIPS 204:
  - splits each 64-bit squeezed word into 16 half-bytes;
  - rejects out-of-range nibbles;
  - maps accepted nibbles to coefficients in [-eta, eta], reduced mod q.
- Emits exactly 256 coefficients per polynomial, then pulses done.
- Sits inside Data_Path between the SHA squeeze output and the s1/s2 coefficient store.

Parameters:
- N, 256, coefficients per polynomial.
- Q, 8380417, ML-DSA modulus.
- COEF_W, 23, coefficient width (ceil(log2 Q)).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new polynomial; sampled only in IDLE.
- eta_sel  in  1  0: eta=2 (ML-DSA-44/87); 1: eta=4 (ML-DSA-65); latched on start.
- word_in  in  64  squeezed SHAKE256 word; byte 0 at [7:0].
- word_valid  in  1  word_in valid.
- word_ready  out  1  sampler accepts word_in this cycle; doubles as squeeze request to the SHA controller.
- coef_out  out  COEF_W  coefficient in [0, Q-1].
- coef_idx  out  8  index 0..255 of coef_out.
- coef_valid  out  1  coef_out/coef_idx valid.
- coef_ready  in  1  downstream store accepts coefficient.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after coefficient 255 handshakes.

Behaviour:
- Reset values: all outputs 0; state IDLE; buffer empty; nibble pointer 0; coefficient count 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Latch eta_sel, clear count, pointer and buffer.
  - RUN -> DONE on the handshake (coef_valid & coef_ready) of index 255.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
- Word buffer: one 64-bit register plus a valid flag.
  - Word handshake is word_valid & word_ready.
  - Nibble k = word[4k+3:4k], k = 0..15, consumed in ascending k.
- Per cycle in RUN with the buffer valid, examine nibble b = buf[4p+3:4p]:
  - eta=2: accept iff b<15; value = 2 - (b mod 5).
  - eta=4: accept iff b<9; value = 4 - b.
  - Negative value v is output as Q+v. Example: -2 -> 8380415.
- Output is combinational from the buffer (zero latency):
  - coef_valid = RUN & buffer valid & accept.
  - Stall (pointer holds) while coef_valid & !coef_ready.
- Nibble consumed means rejected, or accepted with coef_ready. Consumption advances p.
  - Consuming nibble 15 empties the buffer unless it refills in the same cycle.
- word_ready = RUN & (buffer empty | (p==15 & nibble consumed this cycle)).
  - This gives back-to-back words with no bubble; worst case is 16 cycles per word.
- Rate: at most one coefficient per cycle.
- Count reaching 256 ends the polynomial:
  - remaining buffered nibbles are discarded and the buffer is flushed;
  - word_ready is low in DONE/IDLE.
- Simultaneous events: the final coefficient handshake and a word offered in the same cycle do not take the word (word_ready is forced low when the count is 255 and a handshake occurs).
- Reset mid-operation: immediate return to IDLE with state cleared. No done pulse.
- Arithmetic:
  - b mod 5 uses a 4-bit lookup, no divider.
  - Q+v computed in COEF_W bits.

Optional Feature:
- Macro EXPANDS_REJ_CNT_EN.
- Defined:
  - adds output rej_cnt [11:0], counting rejected nibbles for the current polynomial;
  - saturates at 4095, clears on start, holds its value after done.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package mldsa_pkg holds:
  - constants Q, N, COEF_W;
  - eta encoding (ETA2=0, ETA4=1);
  - FSM state typedef.
- One natural sub-module, rej_eta_map: combinational nibble + eta_sel -> {accept, coef[COEF_W-1:0]}.
  - Reusable by the ExpandMask/SampleInBall neighbours.

Test Plan:
- eta=2, word 0x...F7410 (low nibbles 0,1,4,7,F):
  - coefficients idx0..3 = 2, 1, 8380415, 0;
  - the F nibble is rejected (no coef_valid that cycle).
- eta=4, word with nibbles 8,9,0,3:
  - outputs 8380413, 4, 1 at consecutive indices;
  - 9 is rejected.
- All-zero words continuously, eta=2, coef_ready=1:
  - 256 coefficients of value 2 in 256 cycles after the first word;
  - word_ready high every 16th cycle;
  - done pulses once, then busy=0.
- coef_ready toggled randomly, eta=4, random words:
  - coefficient sequence matches the software RejBoundedPoly model;
  - no loss or duplication while coef_valid is held stable.
- Word containing the 256th accepted nibble at k=5:
  - nibbles 6..15 are discarded;
  - word_ready=0 in that cycle and in DONE;
  - a subsequent start resumes cleanly at idx 0.
- Reset asserted at idx 100: outputs go to 0 and the FSM to IDLE; a new start produces idx 0 first.
  - With EXPANDS_REJ_CNT_EN, rej_cnt also reads 0.
